alu_divider_seq: RTL and testbench

// - Iterative radix-2 non-restoring integer divider; the inverse arithmetic path to the prefix adder tree.
// - Sits beside the adder in the ALU and serves DIV/DIVU/REM/REMU for the execute stage.
// - Performs one shift-and-add/subtract per cycle through a DATA_W+1 wide add/sub datapath.
// - Uses a valid/ready handshake on both sides, so execute stalls while a divide is in flight.

---
 rtl/alu_divider_seq.sv | 159 +++++++++++++++
 tb/tb_alu_divider_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_divider_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_divider_seq: iterative radix-2 non-restoring divider, valid/ready I/O  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_divider_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [DATA_W-1:0] c_int_min  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W:0]     acc_q, acc_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;
  logic                div_zero_q, div_zero_d;

  logic [DATA_W-1:0]   w_dividend_abs;
  logic [DATA_W-1:0]   w_divisor_abs;
  logic [DATA_W:0]     w_dvs_ext;
  logic [DATA_W:0]     w_acc_shift;
  logic [DATA_W:0]     w_acc_step;
  logic [DATA_W:0]     w_acc_fix;
  logic [DATA_W-1:0]   w_rem_mag;

  always_comb begin
    w_dividend_abs = (is_signed && dividend[DATA_W-1]) ? (~dividend + 1'b1) : dividend;
    w_divisor_abs  = (is_signed && divisor[DATA_W-1])  ? (~divisor + 1'b1)  : divisor;
    w_dvs_ext      = {1'b0, dvs_q};
    w_acc_shift    = {acc_q[DATA_W-1:0], quo_q[DATA_W-1]};
    // Operation chosen by the sign of the partial remainder before the shift
    w_acc_step     = acc_q[DATA_W] ? (w_acc_shift + w_dvs_ext) : (w_acc_shift - w_dvs_ext);
    w_acc_fix      = acc_q[DATA_W] ? (acc_q + w_dvs_ext) : acc_q;
    w_rem_mag      = w_acc_fix[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_quo_d = is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          neg_rem_d = is_signed & dividend[DATA_W-1];
          dvs_d     = w_divisor_abs;
          quo_d     = w_dividend_abs;
          acc_d     = '0;
          cnt_d     = c_cnt_init;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            state_d     = S_DONE;
          end else if (is_signed && (dividend == c_int_min) && (divisor == '1)) begin
            quotient_d  = dividend;
            remainder_d = '0;
            div_zero_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            div_zero_d  = 1'b0;
            state_d     = S_ITER;
          end
        end
      end
      S_ITER: begin
        acc_d = w_acc_step;
        quo_d = {quo_q[DATA_W-2:0], ~w_acc_step[DATA_W]};
        cnt_d = cnt_q - c_cnt_one;
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        acc_d       = w_acc_fix;
        quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_rem_q ? (~w_rem_mag + 1'b1) : w_rem_mag;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          div_zero_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_divider_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_divider_seq: directed vector bench for alu_divider_seq              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_divider_seq;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_zero;

  int checks;
  int errors;

  alu_divider_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for the result, then complete the handshake.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output logic busy_bad);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0003;
    lat       = 1;
    busy_bad  = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_bad = 1'b1;
    q  = quotient;
    r  = remainder;
    dz = div_zero;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q, r, q0, r0;
    logic        dz, dz0, bb;
    int          lat;

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34};
    vecs[2]  = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 34};
    vecs[3]  = '{1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1, 1};
    vecs[4]  = '{1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  1'b1, 1};
    vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1};
    vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 34};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,         1'b0, 34};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34};
    vecs[9]  = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 34};
    vecs[10] = '{1'b1, 32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 1};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 34};

    rst       = 1'b1;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient",  quotient,       32'd0);
    chk("reset_remainder", remainder,      32'd0);
    chk("reset_div_zero",  32'(div_zero),  32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, lat, bb);
      chk($sformatf("v%0d_quotient", i),  q,          vecs[i].q);
      chk($sformatf("v%0d_remainder", i), r,          vecs[i].r);
      chk($sformatf("v%0d_div_zero", i),  32'(dz),    32'(vecs[i].dz));
      chk($sformatf("v%0d_latency", i),   32'(lat),   32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_ready", i), 32'(bb),   32'd0);
      handshake();
      chk($sformatf("v%0d_idle_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_dz_clear", i),   32'(div_zero), 32'd0);
    end

    // Back-pressure: hold result for 10 cycles while new inputs are offered
    run_op(1'b0, 32'd100, 32'd7, q0, r0, dz0, lat, bb);
    chk("bp_quotient", q0, 32'd14);
    in_valid  = 1'b1;
    dividend  = 32'd999;
    divisor   = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_q", k),     quotient,        q0);
      chk($sformatf("bp_hold%0d_r", k),     remainder,       r0);
      chk($sformatf("bp_hold%0d_dz", k),    32'(div_zero),   32'(dz0));
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready),   32'd0);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid),  32'd1);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_after_ready", 32'(in_ready),  32'd1);
    chk("bp_after_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of the iteration phase
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_quotient",  quotient,       32'd0);
    chk("rst_mid_remainder", remainder,      32'd0);
    chk("rst_mid_div_zero",  32'(div_zero),  32'd0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h10, q, r, dz, lat, bb);
    chk("post_rst_quotient",  q,        32'h0FFFFFFF);
    chk("post_rst_remainder", r,        32'h0000000F);
    chk("post_rst_latency",   32'(lat), 32'd34);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
